// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache: 32-bit cpu port in front of a
// 256-bit line-granular physical memory port. All tag/data storage lives in flops.
module l1_cache #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  input  logic         pmem_resp,
  input  logic [255:0] pmem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata
);

  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_e;

  state_e               state_q, state_d;
  logic [SETS-1:0]      valid_q, valid_d;
  logic [SETS-1:0]      dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [255:0]         data_q [SETS];

  logic [S_INDEX-1:0]   idx;
  logic [TAG_W-1:0]     tag;
  logic [2:0]           word;
  logic                 req, hit, wr_hit, wb_done, fill_done;
  logic [255:0]         line_wr;
  logic                 unused_addr_bits;

  assign idx  = mem_address[4+S_INDEX:5];
  assign tag  = mem_address[31:5+S_INDEX];
  assign word = mem_address[4:2];
  assign unused_addr_bits = ^mem_address[1:0];

  assign req       = mem_read | mem_write;
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  // A simultaneous read+write is serviced as a write.
  assign wr_hit    = mem_resp && mem_write;
  assign wb_done   = (state_q == WRITEBACK) && pmem_resp;
  assign fill_done = (state_q == FILL) && pmem_resp;

  assign mem_rdata  = data_q[idx][{word, 5'b0} +: 32];
  assign pmem_wdata = data_q[idx];

  always_comb begin
    line_wr = data_q[idx];
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) begin
        line_wr[{word, b[1:0], 3'b0} +: 8] = mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: if (pmem_resp) state_d = FILL;
      FILL:      if (pmem_resp) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {mem_address[31:5], 5'b0};
    unique case (state_q)
      IDLE:      mem_resp = req && hit && !rst;
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[idx], idx, 5'b0};
      end
      FILL:      pmem_read = 1'b1;
      default:   ;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill_done) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (wb_done) begin
      dirty_d[idx] = 1'b0;
    end else if (wr_hit) begin
      dirty_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Line storage carries no reset; validity is tracked by valid_q alone.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_q[idx] <= pmem_rdata;
      tag_q[idx]  <= tag;
    end else if (wr_hit) begin
      data_q[idx] <= line_wr;
    end
  end

endmodule

// File: tb/tb_l1_cache.sv
// Bench for l1_cache: pmem responder with programmable latency, a word-level view of
// memory plus residency bookkeeping as reference, directed cases then random traffic.
module tb_l1_cache;

  localparam int SI = 3;

  logic         clk, rst;
  logic         mem_read, mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address, mem_wdata, mem_rdata;
  logic         mem_resp;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;

  l1_cache #(.S_INDEX(SI)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit           w;
    logic [31:0]  a;
    logic [255:0] d;
  } txn_t;

  int           n_chk = 0;
  int           n_fail = 0;
  int           lat = 5;
  bit           spur = 0;
  txn_t         pmem_log[$];
  logic [255:0] pmem_q [bit [26:0]];
  logic [31:0]  view [bit [29:0]];
  bit           vld_m [8];
  bit           drt_m [8];
  logic [23:0]  tag_m [8];
  logic [31:0]  last_rdata;
  int           last_cyc;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Power-on content: line at 0x40 holds 0x1000_0000+i, other lines are distinct.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    logic [26:0] ln;
    ln = a[31:5] - 27'd2;
    return 32'h1000_0000 + {2'b00, ln, a[4:2]};
  endfunction

  function automatic logic [255:0] get_line(input bit [26:0] ln);
    logic [255:0] l;
    if (pmem_q.exists(ln)) return pmem_q[ln];
    for (int i = 0; i < 8; i++) l[32*i +: 32] = init_word({ln, i[2:0], 2'b00});
    return l;
  endfunction

  function automatic logic [31:0] read_view(input bit [29:0] wa);
    if (view.exists(wa)) return view[wa];
    return init_word({wa, 2'b00});
  endfunction

  function automatic logic [255:0] view_line(input logic [26:0] ln);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = read_view({ln, i[2:0]});
    return l;
  endfunction

  // Reset throws away dirty lines: the cpu-visible value reverts to pmem contents.
  task automatic model_reset();
    logic [255:0] l;
    for (int s = 0; s < 8; s++) begin
      if (vld_m[s] && drt_m[s]) begin
        l = get_line({tag_m[s], s[2:0]});
        for (int i = 0; i < 8; i++) view[{tag_m[s], s[2:0], i[2:0]}] = l[32*i +: 32];
      end
      vld_m[s] = 0;
      drt_m[s] = 0;
    end
  endtask

  // pmem responder: answers after lat cycles of a held request; optional stray pulse when idle.
  initial begin
    int cnt;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            pmem_q[pmem_address[31:5]] = pmem_wdata;
            pmem_log.push_back('{w: 1'b1, a: pmem_address, d: pmem_wdata});
          end else begin
            pmem_rdata = get_line(pmem_address[31:5]);
            pmem_log.push_back('{w: 1'b0, a: pmem_address, d: pmem_rdata});
          end
        end
      end else begin
        cnt = 0;
        if (spur) begin
          spur = 0;
          pmem_resp = 1'b1;
          pmem_rdata = {8{32'hBAD0_BAD0}};
        end
      end
    end
  end

  // Per-cycle protocol checks while out of reset.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (pmem_read || pmem_write) begin
          chk("pmem_rw_exclusive", pmem_read && pmem_write, 0);
          chk("pmem_addr_align", pmem_address[4:0], 0);
        end
        if (mem_resp) chk("resp_without_req", mem_read || mem_write, 1);
      end
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    bit got;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = a; mem_byte_enable = be; mem_wdata = wd;
    got = 0;
    last_cyc = 0;
    while (!got && last_cyc < 200) begin
      #2;
      if (mem_resp) begin
        got = 1;
        last_rdata = mem_rdata;
      end else begin
        @(negedge clk);
        last_cyc++;
      end
    end
    if (!got) chk("resp_timeout", 0, 1);
    @(negedge clk);
    mem_read = 0; mem_write = 0;
  endtask

  task automatic check_access(input string nm, input bit rd, input bit wr, input logic [31:0] a,
                              input logic [3:0] be, input logic [31:0] wd);
    logic [2:0]   idx;
    logic [23:0]  tg;
    logic [31:0]  w, vaddr;
    logic [255:0] vdata;
    bit           hit, dv;
    int           exp_cyc, exp_n;
    idx = a[7:5];
    tg = a[31:8];
    hit = vld_m[idx] && tag_m[idx] == tg;
    dv = !hit && vld_m[idx] && drt_m[idx];
    exp_cyc = hit ? 0 : (dv ? 2*lat + 1 : lat + 1);
    exp_n = hit ? 0 : (dv ? 2 : 1);
    vaddr = {tag_m[idx], idx, 5'b0};
    vdata = view_line(vaddr[31:5]);
    pmem_log.delete();
    access(rd, wr, a, be, wd);
    chk({nm, "_latency"}, last_cyc, exp_cyc);
    if (rd && !wr) chk({nm, "_rdata"}, last_rdata, read_view(a[31:2]));
    chk({nm, "_pmem_count"}, pmem_log.size(), exp_n);
    if (pmem_log.size() == exp_n && exp_n > 0) begin
      if (dv) begin
        chk({nm, "_wb_kind"}, pmem_log[0].w, 1);
        chk({nm, "_wb_addr"}, pmem_log[0].a, vaddr);
        chk({nm, "_wb_data"}, pmem_log[0].d, vdata);
      end
      chk({nm, "_fill_kind"}, pmem_log[exp_n-1].w, 0);
      chk({nm, "_fill_addr"}, pmem_log[exp_n-1].a, {a[31:5], 5'b0});
    end
    if (!hit) begin
      vld_m[idx] = 1; tag_m[idx] = tg; drt_m[idx] = 0;
    end
    if (wr) begin
      w = read_view(a[31:2]);
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      view[a[31:2]] = w;
      drt_m[idx] = 1;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1; mem_read = 0; mem_write = 0; mem_byte_enable = 0; mem_address = 0; mem_wdata = 0;
    for (int s = 0; s < 8; s++) begin vld_m[s] = 0; drt_m[s] = 0; tag_m[s] = 0; end
    repeat (3) @(negedge clk);
    chk("reset_mem_resp", mem_resp, 0);
    chk("reset_pmem_read", pmem_read, 0);
    chk("reset_pmem_write", pmem_write, 0);
    rst = 0;

    lat = 5;
    check_access("cold_rd40", 1, 0, 32'h40, 4'h0, 0);
    chk("cold_rd40_lit_data", last_rdata, 32'h1000_0000);
    chk("cold_rd40_lit_cyc", last_cyc, 6);
    chk("cold_rd40_lit_addr", pmem_log.size() > 0 ? pmem_log[0].a : 32'hx, 32'h40);
    check_access("hit_rd44", 1, 0, 32'h44, 4'h0, 0);
    chk("hit_rd44_lit", last_rdata, 32'h1000_0001);
    chk("hit_rd44_lit_cyc", last_cyc, 0);
    check_access("wr48", 0, 1, 32'h48, 4'b0011, 32'hDEAD_BEEF);
    chk("wr48_lit_cyc", last_cyc, 0);
    check_access("rd48", 1, 0, 32'h48, 4'h0, 0);
    chk("rd48_lit", last_rdata, 32'h1000_BEEF);
    check_access("dirty_rd140", 1, 0, 32'h140, 4'h0, 0);
    chk("dirty_rd140_lit_cyc", last_cyc, 11);
    if (pmem_log.size() == 2) begin
      chk("dirty_wb_lit_addr", pmem_log[0].a, 32'h40);
      chk("dirty_wb_lit_word2", pmem_log[0].d[95:64], 32'h1000_BEEF);
      chk("dirty_fill_lit_addr", pmem_log[1].a, 32'h140);
    end
    check_access("clean_rd40", 1, 0, 32'h40, 4'h0, 0);
    chk("clean_rd40_lit_n", pmem_log.size(), 1);

    spur = 1;
    repeat (3) @(negedge clk);
    check_access("after_spur_rd44", 1, 0, 32'h44, 4'h0, 0);
    chk("after_spur_lit", last_rdata, 32'h1000_0001);

    // Request withdrawn while the fill is outstanding.
    lat = 6;
    @(negedge clk);
    mem_read = 1; mem_address = 32'h2080;
    k = 0;
    do begin @(negedge clk); #2; k++; end while (!pmem_read && k < 10);
    chk("drop_fill_start", pmem_read, 1);
    @(negedge clk);
    mem_read = 0;
    k = 0;
    #2;
    while (pmem_read && k < 30) begin
      chk("drop_no_resp", mem_resp, 0);
      @(negedge clk); #2; k++;
    end
    chk("drop_fill_end", pmem_read, 0);
    vld_m[4] = 1; tag_m[4] = 24'h20; drt_m[4] = 0;
    check_access("drop_rd2080", 1, 0, 32'h2080, 4'h0, 0);
    chk("drop_rd2080_lit_cyc", last_cyc, 0);

    // Reset in the middle of a fill.
    lat = 50;
    @(negedge clk);
    mem_read = 1; mem_address = 32'h1060;
    k = 0;
    do begin @(negedge clk); #2; k++; end while (!pmem_read && k < 10);
    chk("rstfill_start", pmem_read, 1);
    @(negedge clk);
    rst = 1; mem_read = 0;
    #2;
    chk("rstfill_no_resp", mem_resp, 0);
    @(posedge clk);
    #1;
    chk("rstfill_pmem_read", pmem_read, 0);
    chk("rstfill_pmem_write", pmem_write, 0);
    chk("rstfill_mem_resp", mem_resp, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    lat = 3;
    check_access("post_rst_rd44", 1, 0, 32'h44, 4'h0, 0);
    chk("post_rst_lit_cyc", last_cyc, 4);
    chk("post_rst_lit_data", last_rdata, 32'h1000_0001);

    for (int n = 0; n < 300; n++) begin
      int op;
      logic [31:0] a;
      logic [1:0] tsel;
      logic [2:0] ix, wi;
      logic [1:0] lo;
      lat = $urandom_range(1, 6);
      tsel = 2'($urandom_range(0, 3));
      ix = 3'($urandom_range(0, 7));
      wi = 3'($urandom_range(0, 7));
      lo = 2'($urandom_range(0, 3));
      a = {22'd0, tsel, ix, wi, lo};
      op = $urandom_range(0, 9);
      if (op < 5) check_access("rand_rd", 1, 0, a, 4'h0, 0);
      else if (op < 9) check_access("rand_wr", 0, 1, a, 4'($urandom_range(0, 15)), $urandom);
      else check_access("rand_rdwr", 1, 1, a, 4'($urandom_range(0, 15)), $urandom);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
